ucdp_latch_wr: RTL

Write sequencer for a bank of depth_p latch entries, each a ucdp_latch-style storage cell with a load enable and a shared data input. It accepts write requests over a valid/ready handshake and drives the shared data bus and the per-entry load enables with a guaranteed setup/pulse/hold sequence, so latch contents are never captured on a changing bus. After reset it initialises every entry to rstval_p before accepting requests. It sits between a register-access front end and the latch bank.

---
 rtl/ucdp_latch_wr.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ucdp_latch_wr.sv
// Write sequencer for a latch bank: initialises every entry to rstval_p after reset,
// then serialises valid/ready writes into setup / load-pulse / hold sequences.
module ucdp_latch_wr #(
    parameter int unsigned          width_p  = 1,
    parameter int unsigned          depth_p  = 4,
    parameter logic [width_p-1:0]   rstval_p = '0,
    localparam int unsigned         addrw_p  = (depth_p > 1) ? $clog2(depth_p) : 1
) (
    input  logic               main_clk_i,
    input  logic               main_rst_i,
    input  logic               wr_valid_i,
    output logic               wr_ready_o,
    input  logic [addrw_p-1:0] wr_addr_i,
    input  logic [width_p-1:0] wr_data_i,
    output logic [depth_p-1:0] ld_o,
    output logic [width_p-1:0] d_o,
    output logic               busy_o,
    output logic               init_done_o,
    output logic               err_o
);

    typedef enum logic [2:0] {
        INIT_SETUP,
        INIT_LOAD,
        INIT_HOLD,
        IDLE,
        SETUP,
        LOAD,
        HOLD
    } state_t;

    state_t             state, state_nxt;
    logic [addrw_p-1:0] idx, idx_nxt;
    logic [addrw_p-1:0] addr, addr_nxt;
    logic [depth_p-1:0] ld, ld_nxt;
    logic [width_p-1:0] d, d_nxt;
    logic               ready, ready_nxt;
    logic               busy, busy_nxt;
    logic               done, done_nxt;
    logic               err, err_nxt;
    logic               accept;
    logic               out_of_range;

    assign accept       = wr_valid_i & ready;
    assign out_of_range = 32'(wr_addr_i) >= depth_p;

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            state <= INIT_SETUP;
            idx   <= '0;
            addr  <= '0;
            ld    <= '0;
            d     <= rstval_p;
            ready <= 1'b0;
            busy  <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            addr  <= addr_nxt;
            ld    <= ld_nxt;
            d     <= d_nxt;
            ready <= ready_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

    // Out-of-range requests pass through HOLD so the error cycle still reads as busy.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        addr_nxt  = addr;
        case (state)
            INIT_SETUP: state_nxt = INIT_LOAD;
            INIT_LOAD:  state_nxt = INIT_HOLD;
            INIT_HOLD: begin
                if (32'(idx) == depth_p - 1) begin
                    state_nxt = IDLE;
                end else begin
                    idx_nxt   = idx + addrw_p'(1);
                    state_nxt = INIT_SETUP;
                end
            end
            IDLE: begin
                if (accept) begin
                    addr_nxt  = wr_addr_i;
                    state_nxt = out_of_range ? HOLD : SETUP;
                end
            end
            SETUP:   state_nxt = LOAD;
            LOAD:    state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = INIT_SETUP;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight off a flop.
    always_comb begin
        ld_nxt = '0;
        for (int unsigned i = 0; i < depth_p; i++) begin
            ld_nxt[i] = ((state_nxt == LOAD) && (32'(addr) == i)) ||
                        ((state_nxt == INIT_LOAD) && (32'(idx) == i));
        end
        d_nxt = d;
        if (accept && !out_of_range) begin
            d_nxt = wr_data_i;
        end
        if (state_nxt == INIT_SETUP) begin
            d_nxt = rstval_p;
        end
        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = done | (state_nxt == IDLE);
        err_nxt   = accept & out_of_range;
    end

    assign wr_ready_o  = ready;
    assign ld_o        = ld;
    assign d_o         = d;
    assign busy_o      = busy;
    assign init_done_o = done;
    assign err_o       = err;

endmodule
